// File: rtl/seq_mul_shift_add.sv
// Sequential shift-add multiplier with a start/done handshake.
// Signed operands are multiplied as magnitudes; the sign is applied in FIN.
module seq_mul_shift_add #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [SW-1:0]        step_q, step_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;

  logic                 effSigned;
  logic [2*WIDTH-1:0]   addend;
  logic [WIDTH-1:0]     mplierShift;
  logic [SW-1:0]        stepNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      step_q    <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    step_d      = step_q;
    neg_d       = neg_q;
    product_d   = product_q;
    done_d      = 1'b0;
    effSigned   = signed_mode & SIGNED_EN;
    addend      = {{WIDTH{1'b0}}, mcand_q} << step_q;
    mplierShift = mplier_q >> 1;
    stepNext    = step_q + SW'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          neg_d    = effSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
          mcand_d  = (effSigned & a[WIDTH-1]) ? -a : a;
          mplier_d = (effSigned & b[WIDTH-1]) ? -b : b;
          acc_d    = '0;
          step_d   = '0;
          state_d  = CALC;
        end
      end
      // Stop as soon as no multiplier bits remain, so small |b| finishes early.
      CALC: begin
        acc_d    = mplier_q[0] ? (acc_q + addend) : acc_q;
        mplier_d = mplierShift;
        step_d   = stepNext;
        if ((mplierShift == '0) || (stepNext == STEP_MAX)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        product_d = neg_q ? -acc_q : acc_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == CALC) || (state_q == FIN);
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Self-checking bench for seq_mul_shift_add (WIDTH=16, SIGNED_EN=1).
// Expected products and latencies come from plain integer arithmetic on the operands.
module tb_seq_mul_shift_add;

  localparam int WIDTH = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              signedMode;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              busy;
  logic              done;
  logic [2*WIDTH-1:0] product;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          sm;
    logic [31:0] p;
    int          n;
  } vec_t;

  seq_mul_shift_add #(.WIDTH(WIDTH), .SIGNED_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_mode(signedMode),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product    (product)
  );

  always #5 clk = ~clk;

  // Exact product of the operands as integers, truncated to 32 bits.
  function automatic logic [31:0] refProduct(logic [15:0] x, logic [15:0] y, bit sm);
    longint px, py, r;
    if (sm) begin
      px = longint'($signed(x));
      py = longint'($signed(y));
    end else begin
      px = longint'(x);
      py = longint'(y);
    end
    r = px * py;
    return r[31:0];
  endfunction

  // Number of multiplier bits that must be examined: position of highest set bit of |b|, at least 1.
  function automatic int refSteps(logic [15:0] y, bit sm);
    int v, n;
    v = sm ? int'($signed(y)) : int'(y);
    if (v < 0) v = -v;
    n = 1;
    for (int i = 0; i < 17; i++) begin
      if (((v >> i) & 1) != 0) n = i + 1;
    end
    return n;
  endfunction

  // Presents an operation for one edge, then scrambles the operand inputs.
  task automatic startOp(input logic [15:0] x, input logic [15:0] y, input bit sm);
    @(negedge clk);
    a = x; b = y; signedMode = sm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    signedMode = 1'($urandom);
  endtask

  // Observes at each negedge after the start edge; lat = edges from start edge to done visible.
  task automatic waitDone(output int lat, output logic [31:0] prod, output int busyCyc,
                          output logic busyAtDone);
    lat = -1; prod = '0; busyCyc = 0; busyAtDone = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k; prod = product; busyAtDone = busy;
        break;
      end
      if (busy === 1'b1) busyCyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; signedMode = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_state busy=%b done=%b product=%h required 0 0 00000000", busy, done, product);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed;
    vec_t vecs[7];
    int lat, busyCyc;
    logic [31:0] prod;
    logic busyAtDone;
    vecs[0] = '{16'h0003, 16'h0005, 1'b0, 32'h0000000F, 3};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16};
    vecs[2] = '{16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, 3};
    vecs[3] = '{16'hFFFD, 16'h0007, 1'b0, 32'h0006FFEB, 3};
    vecs[4] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000, 16};
    vecs[5] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, 15};
    vecs[6] = '{16'h1234, 16'h0000, 1'b1, 32'h00000000, 1};
    foreach (vecs[i]) begin
      startOp(vecs[i].a, vecs[i].b, vecs[i].sm);
      waitDone(lat, prod, busyCyc, busyAtDone);
      checks++;
      if (lat !== vecs[i].n + 1 || prod !== vecs[i].p) begin
        errors++;
        $display("[TB] FAIL directed_%0d lat=%0d product=%h required lat=%0d product=%h",
                 i, lat, prod, vecs[i].n + 1, vecs[i].p);
      end
      checks++;
      if (busyCyc != vecs[i].n + 1 || busyAtDone !== 1'b0) begin
        errors++;
        $display("[TB] FAIL directed_busy_%0d busyCycles=%0d busyAtDone=%b required %0d 0",
                 i, busyCyc, busyAtDone, vecs[i].n + 1);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] x, y;
    bit sm;
    int lat, busyCyc;
    logic [31:0] prod;
    logic busyAtDone;
    for (int i = 0; i < 40; i++) begin
      x = 16'($urandom);
      y = 16'($urandom) >> $urandom_range(0, 15);
      sm = 1'($urandom);
      startOp(x, y, sm);
      waitDone(lat, prod, busyCyc, busyAtDone);
      checks++;
      if (lat !== refSteps(y, sm) + 1 || prod !== refProduct(x, y, sm)) begin
        errors++;
        $display("[TB] FAIL random a=%h b=%h sm=%0d lat=%0d product=%h required lat=%0d product=%h",
                 x, y, sm, lat, prod, refSteps(y, sm) + 1, refProduct(x, y, sm));
      end
    end
  endtask

  task automatic test_start_while_busy;
    int lat, busyCyc, extra;
    logic [31:0] prod;
    logic busyAtDone;
    startOp(16'h1234, 16'h00F0, 1'b0);
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(lat, prod, busyCyc, busyAtDone);
    checks++;
    if (lat !== refSteps(16'h00F0, 1'b0) || prod !== refProduct(16'h1234, 16'h00F0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL start_while_busy lat=%0d product=%h required lat=%0d product=%h",
               lat + 1, prod, refSteps(16'h00F0, 1'b0) + 1, refProduct(16'h1234, 16'h00F0, 1'b0));
    end
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL start_not_queued activeCycles=%0d required 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int lat, busyCyc;
    logic [31:0] prod;
    logic busyAtDone;
    startOp(16'h00FF, 16'h0011, 1'b0);
    waitDone(lat, prod, busyCyc, busyAtDone);
    checks++;
    if (prod !== refProduct(16'h00FF, 16'h0011, 1'b0)) begin
      errors++;
      $display("[TB] FAIL b2b_first product=%h required %h", prod, refProduct(16'h00FF, 16'h0011, 1'b0));
    end
    a = 16'hFFF0; b = 16'h0003; signedMode = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1 || product !== refProduct(16'h00FF, 16'h0011, 1'b0)) begin
      errors++;
      $display("[TB] FAIL b2b_accept busy=%b product=%h required 1 %h",
               busy, product, refProduct(16'h00FF, 16'h0011, 1'b0));
    end
    waitDone(lat, prod, busyCyc, busyAtDone);
    checks++;
    if (lat !== refSteps(16'h0003, 1'b1) + 1 || prod !== refProduct(16'hFFF0, 16'h0003, 1'b1)) begin
      errors++;
      $display("[TB] FAIL b2b_second lat=%0d product=%h required lat=%0d product=%h",
               lat, prod, refSteps(16'h0003, 1'b1) + 1, refProduct(16'hFFF0, 16'h0003, 1'b1));
    end
  endtask

  task automatic test_reset_midop;
    int lat, busyCyc, extra;
    logic [31:0] prod;
    logic busyAtDone;
    startOp(16'hFFFF, 16'hFFFF, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_midop busy=%b done=%b product=%h required 0 0 00000000", busy, done, product);
    end
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL reset_no_done donePulses=%0d required 0", extra);
    end
    startOp(16'h0002, 16'h0002, 1'b0);
    waitDone(lat, prod, busyCyc, busyAtDone);
    checks++;
    if (lat !== 3 || prod !== 32'h4) begin
      errors++;
      $display("[TB] FAIL after_reset lat=%0d product=%h required lat=3 product=00000004", lat, prod);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_start_while_busy;
    test_back_to_back;
    test_reset_midop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mul_shift_add.md
Name: seq_mul_shift_add

Overview:
- Parametrised sequential shift-add multiplier with a start/done handshake.
- Successor to the fixed 16-bit repeated-addition multiplier. Completes in at most WIDTH steps instead of one step per unit of the multiplier, and produces a full 2*WIDTH-bit result.
- Supports unsigned and, optionally, two's-complement signed operands.
- Terminates early once the remaining multiplier bits are zero.
- Sits as a datapath engine under a controller or bus wrapper, which issues one operation at a time.

Parameters:
- WIDTH, 16, operand width in bits (minimum 2).
- SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, always unsigned.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = treat a and b as two's complement; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while in CALC or FIN.
- done  output  1  one-cycle pulse; product valid from this cycle.
- product  output  2*WIDTH  result; held until the next done.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, product=0, all internal registers 0.
- Reset mid-operation: abort at that edge. Next cycle is IDLE with the reset values above; no done is generated.
- States:
  - IDLE: waits for start.
  - CALC: one multiplier bit per cycle.
  - FIN: applies the sign and registers the result.
  - After FIN the block returns to IDLE.
- IDLE, start=1 at edge E0:
  - Latch eff_signed = signed_mode & SIGNED_EN.
  - Latch mcand = |a| and mplier = |b|, both as WIDTH-bit unsigned magnitudes.
  - Latch neg = eff_signed & (a[MSB] ^ b[MSB]).
  - Clear the 2*WIDTH accumulator and the step counter. Go to CALC.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which is representable unsigned. No overflow is possible in any mode.
- CALC, each edge:
  - If mplier[0], acc += mcand << step.
  - Then mplier >>= 1 and step++.
  - Go to FIN when the shifted mplier == 0 or step reaches WIDTH. Otherwise stay in CALC.
- CALC length N: N = max(1, index of the highest set bit of |b| + 1). Range 1..WIDTH.
- FIN edge, edge E0+N+1:
  - product <= neg ? -acc : acc, computed mod 2^(2*WIDTH).
  - done <= 1, state <= IDLE.
  - done is high for exactly one cycle and falls at E0+N+2.
- Latency: done is visible N+1 cycles after the start-sampling edge.
- busy timing: busy=1 from E0+1 through E0+N+1, i.e. in CALC and FIN. busy=0 in the done cycle, because the state is already IDLE.
- Back-to-back: start asserted during the done cycle is accepted, since the block is in IDLE. The new product replaces the old one only at the next done.
- start while busy: ignored, with no effect on state or operands. It is not queued.
- Inputs a, b and signed_mode may change freely after E0; only the E0 values are used.
- Zero result: product=0 when a=0 or b=0. neg still applies, but -0 = 0.
- Unsigned mode: product = a*b, exact in 2*WIDTH bits.
- Signed mode: product = signed(a)*signed(b), exact in 2*WIDTH-bit two's complement.

Test Plan:
All cases use WIDTH=16, SIGNED_EN=1.
- Unsigned 3*5: start with a=3, b=5, signed_mode=0 → N=3, done at E0+4, product=0x0000000F. busy is high for exactly 4 cycles.
- Unsigned full scale: a=0xFFFF, b=0xFFFF → N=16, done at E0+17, product=0xFFFE0001.
- Signed mixed: a=0xFFFD (-3), b=0x0007, signed_mode=1 → N=3, product=0xFFFFFFEB (-21). The same operands with signed_mode=0 give 0x0006FFEB.
- Signed extremes:
  - a=b=0x8000 → product=0x40000000, N=16.
  - a=0x8000, b=0x7FFF → product=0xC0008000.
- Zero and handshake:
  - b=0 → N=1, done at E0+2, product=0.
  - start pulsed at E0+1 with other operands → ignored.
  - start held during the done cycle → a second operation is accepted and completes correctly.
- Reset: assert rst at E0+5 of a 0xFFFF*0xFFFF run → next cycle busy=0, done=0, product=0, and no done pulse follows. A new 2*2 request then yields product=4 at E0'+3.
